// File: rtl/risky_pkg.sv
`default_nettype none
// risky_pkg: shared widths, the canonical NOP and the fetch-queue entry layout.
// Revision 1.0
package risky_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0,x0,0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: single-clock FIFO with synchronous clear, registered head, occupancy count.
// Revision 1.0
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CW'(DEPTH));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue: credit-based instruction prefetch buffer between instr memory and decode.
// Revision 1.0
module fetch_queue
    import risky_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_re_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic [ILEN-1:0] mem_rdata_i,
    input  logic            mem_rvalid_i,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;

    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;
    fq_entry_t       push_entry;
    fq_entry_t       head;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    // Slots already promised to an outstanding request count as used; a pop
    // in the same cycle is deliberately not credited.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue     = rst_n && !redirect_i && (occupancy < (CW + 1)'(DEPTH));

    assign push = mem_rvalid_i && !drop_q && !redirect_i;
    assign pop  = !empty && !stall_i && !redirect_i;

    assign push_entry = '{pc: req_pc_q, instr: mem_rdata_i};

    assign mem_re_o   = issue;
    assign mem_addr_o = fetch_pc_q;

    assign valid_o = !empty;
    assign instr_o = valid_o ? head.instr : NOP_INSTR;
    assign pc_o    = valid_o ? head.pc    : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (mem_rvalid_i) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
        // A response landing in the redirect cycle is already killed via push;
        // only a request whose data is still to come needs a drop marker.
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            drop_d     = inflight_q && !mem_rvalid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .clear_i     (redirect_i),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

`ifndef SYNTHESIS
    a_rvalid_latency : assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid_i |-> $past(mem_re_o));
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed stimulus with scoreboarded request addresses and decode pops.
// Revision 1.0
module tb_fetch_queue;
    import risky_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  epoch = 8'h0;
    logic [31:0] exp_req_q[$];
    fq_entry_t   exp_pop_q[$];
    bit          strict_req = 1'b0;
    bit          strict_pop = 1'b0;
    fq_entry_t   mon_e;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    // Memory: one-cycle latency, data tagged with the reset epoch.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= '0;
        end else begin
            mem_rvalid_i <= mem_re_o;
            mem_rdata_i  <= mem_addr_o + 32'h100 + {epoch, 24'h0};
        end
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return pc + 32'h100 + {epoch, 24'h0};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares requests and decode pops against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re_o) begin
                if (exp_req_q.size() > 0) begin
                    check32("req_addr", mem_addr_o, exp_req_q.pop_front());
                end else if (strict_req) begin
                    checks++;
                    errors++;
                    $display("FAIL req_extra: got request %h expected none at %0t", mem_addr_o, $time);
                end
            end
            if (valid_o) begin
                if (!stall_i && !redirect_i) begin
                    if (exp_pop_q.size() > 0) begin
                        mon_e = exp_pop_q.pop_front();
                        check32("pop_pc", pc_o, mon_e.pc);
                        check32("pop_instr", instr_o, mon_e.instr);
                    end else if (strict_pop) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_extra: got pc %h expected none at %0t", pc_o, $time);
                    end
                end
            end else begin
                check32("idle_pc", pc_o, 32'h0);
                check32("idle_instr", instr_o, NOP_INSTR);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exp_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic exp_pop(input logic [31:0] pc);
        fq_entry_t e;
        e.pc    = pc;
        e.instr = exp_instr(pc);
        exp_pop_q.push_back(e);
    endtask

    task automatic reset_assert(input bit st);
        rst_n         = 1'b0;
        stall_i       = st;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        #1;
        check32("rst_mem_re", 32'(mem_re_o), 32'h0);
        check32("rst_mem_addr", mem_addr_o, RESET_PC);
        check32("rst_valid", 32'(valid_o), 32'h0);
        check32("rst_instr", instr_o, NOP_INSTR);
        check32("rst_pc", pc_o, 32'h0);
        epoch++;
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic end_test();
        check32("sb_req_left", 32'(exp_req_q.size()), 32'h0);
        check32("sb_pop_left", 32'(exp_pop_q.size()), 32'h0);
        exp_req_q.delete();
        exp_pop_q.delete();
        strict_req = 1'b0;
        strict_pop = 1'b0;
    endtask

    task automatic run_redirect(input bit pre_stall, input logic [31:0] tgt_raw, input logic [31:0] tgt);
        reset_assert(pre_stall);
        strict_req = 1'b1;
        strict_pop = 1'b1;
        exp_req(32'h0); exp_req(32'h4); exp_req(32'h8);
        for (int k = 0; k < 5; k++) exp_req(tgt + 32'(4 * k));
        if (!pre_stall) exp_pop(32'h0);
        exp_pop(tgt);
        reset_release();
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                stall_i       = 1'b0;
                redirect_i    = 1'b1;
                redirect_pc_i = tgt_raw;
            end
            if (c == 4) redirect_i = 1'b0;
            if (c == 7) stall_i = 1'b1;
            smp();
            if (c == 3) check32("redir_no_req", 32'(mem_re_o), 32'h0);
            if (c == 4) begin
                check32("redir_empty", 32'(valid_o), 32'h0);
                check32("redir_req", 32'(mem_re_o), 32'h1);
                check32("redir_addr", mem_addr_o, tgt);
            end
            next();
        end
        end_test();
    endtask

    initial begin
        // Free-running fetch from reset.
        reset_assert(1'b0);
        for (int k = 0; k < 12; k++) exp_req(32'(4 * k));
        for (int k = 0; k < 10; k++) exp_pop(32'(4 * k));
        reset_release();
        for (int c = 0; c < 12; c++) begin
            smp();
            check32("run_valid", 32'(valid_o), (c >= 2) ? 32'h1 : 32'h0);
            next();
        end
        end_test();

        // Stall from reset: fill to DEPTH, then drain.
        reset_assert(1'b1);
        strict_req = 1'b1;
        strict_pop = 1'b1;
        for (int k = 0; k < 4; k++) exp_req(32'(4 * k));
        reset_release();
        for (int c = 0; c < 8; c++) begin
            smp();
            if (c >= 2) check32("stall_head_pc", pc_o, 32'h0);
            if (c == 7) check32("stall_full_no_req", 32'(mem_re_o), 32'h0);
            next();
        end
        for (int k = 4; k < 9; k++) exp_req(32'(4 * k));
        for (int k = 0; k < 5; k++) exp_pop(32'(4 * k));
        for (int c = 8; c < 17; c++) begin
            stall_i = (c >= 13);
            smp();
            if (c == 8) check32("drain_no_req", 32'(mem_re_o), 32'h0);
            if (c == 9) begin
                check32("refetch_req", 32'(mem_re_o), 32'h1);
                check32("refetch_addr", mem_addr_o, 32'h10);
            end
            if (c == 16) check32("refill_no_req", 32'(mem_re_o), 32'h0);
            next();
        end
        end_test();

        // Redirect with a response in flight, then with pop+push+redirect together.
        run_redirect(1'b0, 32'h0000_0203, 32'h0000_0200);
        run_redirect(1'b1, 32'h0000_0401, 32'h0000_0400);

        // Redirect to the top of the address space: fetch wraps to 0.
        reset_assert(1'b0);
        strict_req = 1'b1;
        strict_pop = 1'b1;
        exp_req(32'hFFFF_FFFC);
        for (int k = 0; k < 5; k++) exp_req(32'(4 * k));
        exp_pop(32'hFFFF_FFFC);
        exp_pop(32'h0);
        reset_release();
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = 32'hFFFF_FFFC;
            end
            if (c == 1) redirect_i = 1'b0;
            if (c == 5) stall_i = 1'b1;
            smp();
            if (c == 0) check32("wrap_no_req", 32'(mem_re_o), 32'h0);
            next();
        end
        end_test();

        // Reset with three entries queued and a request in flight.
        reset_assert(1'b1);
        reset_release();
        for (int c = 0; c < 4; c++) next();
        check32("pre_reset_valid", 32'(valid_o), 32'h1);
        reset_assert(1'b0);
        strict_pop = 1'b1;
        for (int k = 0; k < 3; k++) exp_req(32'(4 * k));
        exp_pop(RESET_PC);
        exp_pop(RESET_PC + 32'h4);
        exp_pop(RESET_PC + 32'h8);
        reset_release();
        for (int c = 0; c < 5; c++) begin
            smp();
            if (c < 2) check32("post_reset_empty", 32'(valid_o), 32'h0);
            if (c == 2) check32("post_reset_first_pc", pc_o, RESET_PC);
            next();
        end
        end_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
